// File: rtl/example1_arbiter_pkg.sv
// Shared sizing helpers and parameter limits for the Example1 round-robin sharing controller.
package example1_arbiter_pkg;

    localparam int N_MIN     = 2;
    localparam int N_MAX     = 16;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/example1_arbiter_if.sv
// Client-side and server-side method bundles of the Example1 sharing controller.
interface example1_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
) ();
    logic [N-1:0]   client_say__ENA;
    logic [N*W-1:0] client_say_v;
    logic [N-1:0]   client_say__RDY;
    logic [N-1:0]   client_heard__ENA;
    logic [W-1:0]   client_heard_v;
    logic [N-1:0]   client_heard__RDY;
    logic           server_say__ENA;
    logic [W-1:0]   server_say_v;
    logic           server_say__RDY;
    logic           server_heard__ENA;
    logic [W-1:0]   server_heard_v;
    logic           server_heard__RDY;

    // master: the arbiter; slave: the clients plus the Example1 server around it.
    modport master (
        input  client_say__ENA, client_say_v, client_heard__RDY,
        input  server_say__RDY, server_heard__ENA, server_heard_v,
        output client_say__RDY, client_heard__ENA, client_heard_v,
        output server_say__ENA, server_say_v, server_heard__RDY
    );

    modport slave (
        output client_say__ENA, client_say_v, client_heard__RDY,
        output server_say__RDY, server_heard__ENA, server_heard_v,
        input  client_say__RDY, client_heard__ENA, client_heard_v,
        input  server_say__ENA, server_say_v, server_heard__RDY
    );
endinterface

// File: rtl/example1_tag_fifo.sv
// In-order queue of client tags for requests outstanding at the server.
module example1_tag_fifo
    import example1_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [IW-1:0] din,
    input  logic          pop,
    output logic [IW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = idx_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = nxt(wr_q);
        end
        if (do_pop) begin
            rd_d = nxt(rd_q);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/example1_arbiter.sv
// Round-robin sharing of one Example1 echo server among N clients, with in-order
// routing of each heard indication back to the client whose say it answers.
module example1_arbiter
    import example1_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic               CLK,
    input  logic               RST,
    example1_arbiter_if.master bus,
    output logic               err
);
    localparam int IW = idx_w(N);

    logic [IW-1:0] own_q, own_d;
    logic          err_q, err_d;
    logic [IW-1:0] head;
    logic          full, empty, open, push, pop, head_rdy;
    logic [N-1:0]  say_rdy, head_sel, heard_ena;
    logic [W-1:0]  say_v;

    // The slot rotates on every open cycle, fired or not, so no RDY depends on an ENA.
    assign open = bus.server_say__RDY & ~full;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign say_rdy[i]   = open & (own_q == IW'(i));
        assign head_sel[i]  = ~empty & (head == IW'(i));
        assign heard_ena[i] = bus.server_heard__ENA & head_sel[i];
    end

    always_comb begin
        say_v = '0;
        for (int i = 0; i < N; i++) begin
            if (own_q == IW'(i)) say_v = bus.client_say_v[i*W +: W];
        end
    end

    assign push     = |(bus.client_say__ENA & say_rdy);
    assign head_rdy = |(head_sel & bus.client_heard__RDY);
    assign pop      = bus.server_heard__ENA & head_rdy;

    assign bus.client_say__RDY   = say_rdy;
    assign bus.server_say__ENA   = push;
    assign bus.server_say_v      = say_v;
    assign bus.server_heard__RDY = head_rdy;
    assign bus.client_heard__ENA = heard_ena;
    assign bus.client_heard_v    = bus.server_heard_v;
    assign err                   = err_q;

    always_comb begin
        own_d = own_q;
        if (open) own_d = (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;
        // An indication with nothing outstanding is dropped and flagged until reset.
        err_d = err_q | (bus.server_heard__ENA & empty);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            own_q <= '0;
            err_q <= 1'b0;
        end else begin
            own_q <= own_d;
            err_q <= err_d;
        end
    end

    example1_tag_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_tagq (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (own_q),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule
